// File: rtl/dff_bank_driver.sv
// Command-side controller for an enable/clear flop bank.
// Define DFF_BANK_DRIVER_VERIFY_EN to read back and verify LOAD/CLEAR.
module dff_bank_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] bank_in_1,
    output logic             bank_enable,
    output logic             bank_clear_n,
    input  logic [WIDTH-1:0] bank_out_1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        RESP
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    state_t state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] bank_in_q, bank_in_d;
    logic             en_q, en_d;
    logic             clr_n_q, clr_n_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             re_q, re_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= OP_NOP;
            data_q    <= '0;
            bank_in_q <= '0;
            en_q      <= 1'b0;
            clr_n_q   <= 1'b1;
            rv_q      <= 1'b0;
            rd_q      <= '0;
            re_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            bank_in_q <= bank_in_d;
            en_q      <= en_d;
            clr_n_q   <= clr_n_d;
            rv_q      <= rv_d;
            rd_q      <= rd_d;
            re_q      <= re_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        bank_in_d = bank_in_q;
        en_d      = 1'b0;
        clr_n_d   = 1'b1;
        rv_d      = rv_q;
        rd_d      = rd_q;
        re_d      = re_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    unique case (cmd_op)
                        OP_LOAD: begin
                            bank_in_d = cmd_data;
                            en_d      = 1'b1;
                            state_d   = DRIVE;
                        end
                        OP_CLEAR: begin
                            clr_n_d = 1'b0;
                            state_d = DRIVE;
                        end
                        OP_READ: begin
                            state_d = SAMPLE;
                        end
                        OP_NOP: begin
                            rv_d    = 1'b1;
                            rd_d    = '0;
                            re_d    = 1'b0;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            DRIVE: begin
`ifdef DFF_BANK_DRIVER_VERIFY_EN
                state_d = SAMPLE;
`else
                // Without read-back the response echoes the command.
                rv_d    = 1'b1;
                rd_d    = (op_q == OP_LOAD) ? data_q : '0;
                re_d    = 1'b0;
                state_d = RESP;
`endif
            end
            SAMPLE: begin
                rv_d    = 1'b1;
                rd_d    = bank_out_1;
                re_d    = 1'b0;
                state_d = RESP;
`ifdef DFF_BANK_DRIVER_VERIFY_EN
                if (op_q == OP_LOAD)
                    re_d = (bank_out_1 != data_q);
                else if (op_q == OP_CLEAR)
                    re_d = (bank_out_1 != '0);
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign cmd_ready    = ready_q;
    assign bank_in_1    = bank_in_q;
    assign bank_enable  = en_q;
    assign bank_clear_n = clr_n_q;
    assign rsp_valid    = rv_q;
    assign rsp_data     = rd_q;
    assign rsp_err      = re_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dff_bank_driver.sv
// Bench for dff_bank_driver: directed plus random commands
// against a behavioural bank/response model.
module tb_dff_bank_driver;

    localparam int W = 8;
`ifdef DFF_BANK_DRIVER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] bank_in_1;
    logic         bank_enable;
    logic         bank_clear_n;
    logic [W-1:0] bank_out_1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         busy;

    always #5 clk = ~clk;

    dff_bank_driver #(.WIDTH(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .bank_in_1(bank_in_1),
        .bank_enable(bank_enable),
        .bank_clear_n(bank_clear_n),
        .bank_out_1(bank_out_1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    // Flop bank with a stuck-at-one overlay on its outputs.
    logic [W-1:0] bank_q = '0;
    logic [W-1:0] force_mask = '0;
    always_ff @(posedge clk) begin
        if (!bank_clear_n) bank_q <= '0;
        else if (bank_enable) bank_q <= bank_in_1;
    end
    assign bank_out_1 = bank_q | force_mask;

    int n_assert = 0;
    int n_fail = 0;
    logic [W-1:0] mbank = '0;
    logic [W-1:0] mload = '0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op,
                           input logic [W-1:0] d,
                           input int hold);
        logic [W-1:0] ed;
        logic [W-1:0] seen;
        logic         ee;
        int lat, k, t, en_cnt, clr_cnt, both_cnt;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", cmd_ready, 1);
        if (op == 2'b01) begin
            mbank = d;
            mload = d;
        end else if (op == 2'b10) begin
            mbank = '0;
        end
        seen = mbank | force_mask;
        ed = '0;
        ee = 1'b0;
        lat = 0;
        case (op)
            2'b01: begin
                lat = VERIFY ? 2 : 1;
                ed = VERIFY ? seen : d;
                ee = VERIFY && (seen != d);
            end
            2'b10: begin
                lat = VERIFY ? 2 : 1;
                ed = VERIFY ? seen : '0;
                ee = VERIFY && (seen != '0);
            end
            2'b11: begin
                lat = 1;
                ed = seen;
            end
            default: ;
        endcase
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        rsp_ready = (hold == 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data = W'($urandom);
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", cmd_ready, 0);
        k = 1;
        en_cnt = 0;
        clr_cnt = 0;
        both_cnt = 0;
        while (rsp_valid !== 1'b1 && k < 8) begin
            if (bank_enable) begin
                en_cnt++;
                check("bank_in_strobe", bank_in_1, d);
            end
            if (!bank_clear_n) clr_cnt++;
            if (bank_enable && !bank_clear_n) both_cnt++;
            @(negedge clk);
            k++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        check("latency", k - 1, lat);
        check("rsp_data", rsp_data, ed);
        check("rsp_err", rsp_err, ee);
        check("enable_cycles", en_cnt, (op == 2'b01) ? 1 : 0);
        check("clear_cycles", clr_cnt, (op == 2'b10) ? 1 : 0);
        check("strobe_overlap", both_cnt, 0);
        check("bank_in_kept", bank_in_1, mload);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op = 2'($urandom);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, ed);
            check("hold_err", rsp_err, ee);
            check("hold_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rsp_dropped", rsp_valid, 0);
        check("ready_back", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_enable", bank_enable, 0);
        check("idle_clear_n", bank_clear_n, 1);
    endtask

    initial begin
        logic [1:0] rop;
        logic [W-1:0] rd;
        int rhold;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_bank_in", bank_in_1, 0);
        check("rst_enable", bank_enable, 0);
        check("rst_clear_n", bank_clear_n, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        run_cmd(2'b01, 8'hA5, 0);
        run_cmd(2'b10, 8'h00, 0);
        force_mask = 8'h01;
        run_cmd(2'b01, 8'h3C, 0);
        force_mask = 8'h00;
        run_cmd(2'b01, 8'h5A, 0);
        run_cmd(2'b11, 8'h00, 5);
        run_cmd(2'b00, 8'hFF, 2);

        // Reset while a LOAD is in its drive cycle.
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_data = 8'hC3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("drive_enable", bank_enable, 1);
        reset_n = 1'b0;
        @(negedge clk);
        mbank = 8'hC3;
        mload = '0;
        check("rstd_enable", bank_enable, 0);
        check("rstd_clear_n", bank_clear_n, 1);
        check("rstd_rsp_valid", rsp_valid, 0);
        check("rstd_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstd_ready", cmd_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("rstd_no_rsp", rsp_valid, 0);
        end

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            rd = W'($urandom);
            rhold = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                force_mask = W'(1 << $urandom_range(0, W - 1));
            else
                force_mask = '0;
            run_cmd(rop, rd, rhold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_bank_driver.md
# dff_bank_driver

Command-side controller for a bank of enable/clear D flip-flops. It accepts LOAD, CLEAR and READBACK commands over a valid/ready handshake. It drives the bank's data, enable and active-low clear inputs with single-cycle strobes, samples the bank outputs, and returns a response word with an optional verify-error flag. It sits between a register-access master and a WIDTH-bit flop bank.

## Interface
- WIDTH, 8, bit width of the command data, bank and response
- clk  input  1  rising-edge clock, the only clock
- reset_n  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 NOP, 01 LOAD, 10 CLEAR, 11 READBACK
- cmd_data  input  WIDTH  LOAD value
- bank_in_1  output  WIDTH  data to the bank
- bank_enable  output  1  bank load strobe
- bank_clear_n  output  1  bank clear, active low
- bank_out_1  input  WIDTH  bank outputs
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_data  output  WIDTH  response word
- rsp_err  output  1  verify mismatch
- busy  output  1  high in any state other than IDLE

## Operation
- The FSM has four states: IDLE, DRIVE, SAMPLE and RESP. All outputs are registered.
- Command acceptance:
  - cmd_ready is high only in IDLE with reset_n high.
  - A command is accepted on an edge where cmd_valid and cmd_ready are both high.
  - cmd_op and cmd_data are captured at acceptance.
- Transitions on acceptance:
  - LOAD goes to DRIVE with bank_in_1 set to cmd_data and bank_enable=1.
  - CLEAR goes to DRIVE with bank_clear_n=0 and bank_in_1 unchanged.
  - READBACK goes to SAMPLE.
  - NOP goes to RESP with rsp_data=0 and rsp_err=0.
- DRIVE lasts exactly one cycle. It always moves to SAMPLE and deasserts bank_enable and bank_clear_n (enable=0, clear_n=1).
- SAMPLE lasts exactly one cycle and moves to RESP, setting rsp_valid=1 and rsp_data=bank_out_1. rsp_err is set as follows:
  - LOAD: (bank_out_1 != captured cmd_data).
  - CLEAR: (bank_out_1 != 0).
  - READBACK: 0.
- RESP holds rsp_valid, rsp_data and rsp_err stable until rsp_ready is high at an edge. The FSM then returns to IDLE with rsp_valid=0.
- bank_in_1 keeps its last LOAD value between commands.
- bank_enable and bank_clear_n are never active in the same cycle.

## Timing
- Reset values (reset_n low at an edge): state IDLE, cmd_ready=0, bank_in_1=0, bank_enable=0, bank_clear_n=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. cmd_ready rises on the first edge with reset_n high.
- A reset mid-command abandons it on that edge, including a reset during DRIVE. Any pending strobe is removed, and no response is produced.
- Latency from the accept edge E0 to the first cycle with rsp_valid high:
  - LOAD and CLEAR: 2 edges (E0 to DRIVE, E1 to SAMPLE, E2 to RESP).
  - READBACK: 1 edge after E0 goes to SAMPLE; RESP follows on the next edge.
  - NOP: RESP is entered at E0.
- Strobes: bank_enable or bank_clear_n is active for exactly the DRIVE cycle. The bank captures on edge E1 and bank_out_1 is sampled at edge E2.
- With rsp_ready held high, the command throughput is one command per 4 cycles (LOAD/CLEAR) or 3 cycles (READBACK).
- If rsp_ready is high on the first RESP cycle, the FSM returns to IDLE on the next edge. cmd_ready is high one cycle later, so there is no same-edge re-accept.
- cmd_valid is ignored while busy. cmd_data is not required to stay stable after acceptance.

## Configuration
- Macro: DFF_BANK_DRIVER_VERIFY_EN.
- When defined, LOAD and CLEAR pass through SAMPLE and rsp_err behaves as described in Operation.
- When undefined:
  - LOAD and CLEAR go from DRIVE straight to RESP, with rsp_data set to the captured cmd_data (LOAD) or 0 (CLEAR).
  - rsp_err is tied to 0.
  - LOAD/CLEAR latency is 1 edge shorter.
  - READBACK behaviour is unchanged.

## Test plan
- Reset then LOAD 8'hA5 with a model bank and rsp_ready=1 -> bank_enable is high for exactly 1 cycle with bank_in_1=8'hA5; rsp_valid is high 2 edges after acceptance with rsp_data=8'hA5 and rsp_err=0.
- After the LOAD, send CLEAR -> bank_clear_n is low for exactly 1 cycle; the response has rsp_data=8'h00 and rsp_err=0.
- LOAD 8'h3C with the bank's bit 0 forced to 1 -> rsp_data=8'h3D, rsp_err=1 (VERIFY_EN defined); rsp_err=0 and rsp_data=8'h3C when undefined.
- READBACK with the bank holding 8'h5A and rsp_ready held low for 5 cycles -> rsp_valid and rsp_data=8'h5A stay stable for all 5 cycles; cmd_ready stays 0 while cmd_valid is held high.
- Assert reset_n low during DRIVE of a LOAD -> on that edge bank_enable=0, bank_clear_n=1 and rsp_valid=0; no response follows, and cmd_ready is 1 one edge after release.
